key_scan_pulse: RTL and testbench
=================================

Name: key_scan_pulse

Overview:
- Input front-end for the menu and game screens.
- Scans a 4x4 active-low key matrix and two dedicated push-buttons (select, next), then debounces at scan-frame granularity.
- Outputs a 5-bit held key code `key` and a single-cycle press code `key_pulse`, consumed directly by the menu and game blocks.
- Code map: idle = 5'h1F, select = 5'h1D, next = 5'h1E, matrix keys = 5'h00–5'h0F.

Parameters:
- SCAN_DIV, 25000, clk cycles per column slot (1 ms at 25 MHz); the row sample is taken on the last cycle of the slot. Minimum 2.
- DEBOUNCE_SCANS, 4, number of consecutive identical full frames required before a code is accepted. Minimum 1.

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  reset, asynchronous, active-high
- row_in  in  4  matrix rows, active-low, externally pulled up, asynchronous
- btn_sel  in  1  select button, active-high, raw/asynchronous
- btn_next  in  1  next button, active-high, raw/asynchronous
- col_out  out  4  matrix column drive, active-low, exactly one bit low
- key  out  5  debounced held code; 5'h1F when nothing is pressed
- key_pulse  out  5  accepted code for one clk on press/change; 5'h1F otherwise

Behaviour:
- Synchronisers:
  - 2-FF synchronisers on row_in, btn_sel and btn_next.
  - All later logic uses only the synchronised values.
- Scan timing:
  - div counter runs 0..SCAN_DIV-1 and wraps.
  - At terminal count, the row bits are sampled for the current column c, then c advances 0→1→2→3→0.
  - col_out is the registered value ~(4'b0001<<c).
  - A frame is 4*SCAN_DIV cycles.
- Frame latch:
  - Sampled bit pressed[c*4+r] = ~row_sync[r].
  - On the sample of column 3 (frame end), the raw code is formed from the 16 pressed bits plus the synchronised buttons at that same cycle.
- Raw-code priority:
  - btn_sel → 1D.
  - else btn_next → 1E.
  - else the lowest-index pressed matrix key, code = c*4+r.
  - else 1F.
  - Multiple matrix keys: lowest index wins.
- Debounce FSM (per frame end only):
  - If raw == cand, cnt increments, saturating at DEBOUNCE_SCANS.
  - Otherwise cand <= raw and cnt <= 1.
  - Accept when cnt reaches DEBOUNCE_SCANS with cand != key: key <= cand on the next clk.
  - key_pulse <= cand for exactly that one clk, only if cand != 1F.
- Release: key returns to 1F after DEBOUNCE_SCANS idle frames; no pulse is generated.
- Roll-over:
  - A direct change A→B with no idle frame in between gives key=B and one pulse of B.
  - Holding a key gives no repeat pulses.
- key_pulse is 1F on every cycle except an accept cycle; it is never 1D/1E spuriously.
- Latency: key and key_pulse update 1 clk after the DEBOUNCE_SCANS-th consecutive matching frame end.
- Reset values (asynchronous):
  - col_out = 4'b1110, c = 0, div = 0.
  - key = 1F, key_pulse = 1F, cand = 1F, cnt = 0.
  - Synchronisers = idle (row 4'hF, buttons 0).
  - A reset mid-press discards all history; the press is re-detected only after DEBOUNCE_SCANS full new frames.
- Widths: cnt is $clog2(DEBOUNCE_SCANS+1) bits; div is $clog2(SCAN_DIV) bits; all code arithmetic is 5-bit with no overflow (max 5'h0F from the matrix).

Decomposition:
- Shared package key_pkg:
  - KEY_W = 5.
  - Constants KEY_NONE = 5'h1F, KEY_SEL = 5'h1D, KEY_NEXT = 5'h1E.
  - The menu and game blocks import the same constants.
- Sub-module key_debounce:
  - Contains cand, cnt, and the key/key_pulse registers, driven by frame_end and raw_code.
  - Scanner, synchronisers and priority encoder remain in key_scan_pulse.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, frame = 16 clk):
1. Reset assert then release with all inputs idle → col_out=4'b1110, key=1F, key_pulse=1F throughout. col_out then cycles 1101, 1011, 0111 with 4-clk spacing.
2. btn_next held 10 frames → key=1E one clk after the 3rd frame end. key_pulse=1E for exactly 1 clk; no further pulses. After release, key=1F after 3 idle frames with no pulse.
3. Row 1 pulled low only while col 2 is driven, held 4 frames → key=5'h09 and one pulse of 5'h09. Adding key 3 (col 0, row 3) simultaneously → key becomes 5'h03 with one pulse.
4. btn_next pressed for 1 frame, released 1 frame, pressed 1 frame (bounce) → key stays 1F and key_pulse never leaves 1F.
5. btn_sel and matrix key 5'h07 held together 3 frames → key=1D and a single pulse of 1D; key_pulse never shows 5'h07.
6. rst asserted for 2 clk during the 2nd frame of a held btn_sel → outputs go to 1F immediately. The pulse of 1D occurs only after 3 complete post-reset frames.

Source files
------------

// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg : key code constants and raw-code priority encoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package key_pkg;

   localparam int KEY_W = 5;

   typedef logic [KEY_W-1:0] key_code_t;

   localparam key_code_t KEY_NONE = 5'h1F;
   localparam key_code_t KEY_SEL  = 5'h1D;
   localparam key_code_t KEY_NEXT = 5'h1E;

   // Buttons outrank the matrix; among matrix keys the lowest index wins.
   function automatic key_code_t encode_key(input logic [15:0] pressed,
                                            input logic        sel,
                                            input logic        nxt);
      key_code_t code;
      code = KEY_NONE;
      for (int i = 15; i >= 0; i--) begin
         if (pressed[i]) code = key_code_t'(i);
      end
      if (nxt) code = KEY_NEXT;
      if (sel) code = KEY_SEL;
      return code;
   endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce : frame-granular debounce of the raw key code, press pulse
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_debounce
   import key_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      frame_end_i,
   input  key_code_t raw_code_i,
   output key_code_t key_o,
   output key_code_t key_pulse_o
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   key_code_t        cand_q, cand_d;
   key_code_t        key_q, key_d;
   key_code_t        pulse_q, pulse_d;

   always_comb begin
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      pulse_d = KEY_NONE;
      if (frame_end_i) begin
         if (raw_code_i == cand_q) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
         end else begin
            cand_d = raw_code_i;
            cnt_d  = CNT_W'(1);
         end
         // A release accepts KEY_NONE, so the pulse naturally stays idle.
         if (cnt_d == CNT_MAX && cand_d != key_q) begin
            key_d   = cand_d;
            pulse_d = cand_d;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_q  <= KEY_NONE;
         cnt_q   <= '0;
         key_q   <= KEY_NONE;
         pulse_q <= KEY_NONE;
      end else begin
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         pulse_q <= pulse_d;
      end
   end

   assign key_o       = key_q;
   assign key_pulse_o = pulse_q;

endmodule

`default_nettype wire

// File: rtl/key_scan_pulse.sv
// ---------------------------------------------------------------------------
// key_scan_pulse : 4x4 matrix + button scanner with debounced key/pulse codes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_scan_pulse
   import key_pkg::*;
#(
   parameter int SCAN_DIV       = 25000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       row_in,
   input  logic             btn_sel,
   input  logic             btn_next,
   output logic [3:0]       col_out,
   output logic [KEY_W-1:0] key,
   output logic [KEY_W-1:0] key_pulse
);

   localparam int               DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [3:0]       row_meta_q, row_sync_q;
   logic [1:0]       btn_meta_q, btn_sync_q;   // {next, sel}
   logic [DIV_W-1:0] div_q;
   logic [1:0]       col_q;
   logic [3:0]       col_out_q;
   logic [15:0]      pressed_q, pressed_d;

   logic      w_tc;
   logic      w_frame_end;
   logic [1:0] w_col_nxt;
   key_code_t w_raw_code;

   assign w_tc        = (div_q == DIV_LAST);
   assign w_frame_end = w_tc && (col_q == 2'd3);
   assign w_col_nxt   = col_q + 2'd1;

   // Merge the current column's sample so the frame-end code sees all 16 keys.
   always_comb begin
      pressed_d = pressed_q;
      pressed_d[{col_q, 2'b00} +: 4] = ~row_sync_q;
   end

   assign w_raw_code = encode_key(pressed_d, btn_sync_q[0], btn_sync_q[1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
         btn_meta_q <= 2'b00;
         btn_sync_q <= 2'b00;
         div_q      <= '0;
         col_q      <= 2'd0;
         col_out_q  <= 4'b1110;
         pressed_q  <= '0;
      end else begin
         row_meta_q <= row_in;
         row_sync_q <= row_meta_q;
         btn_meta_q <= {btn_next, btn_sel};
         btn_sync_q <= btn_meta_q;
         if (w_tc) begin
            div_q     <= '0;
            pressed_q <= pressed_d;
            col_q     <= w_col_nxt;
            col_out_q <= ~(4'b0001 << w_col_nxt);
         end else begin
            div_q <= div_q + 1'b1;
         end
      end
   end

   assign col_out = col_out_q;

   key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
   ) u_debounce (
      .clk         (clk),
      .rst         (rst),
      .frame_end_i (w_frame_end),
      .raw_code_i  (w_raw_code),
      .key_o       (key),
      .key_pulse_o (key_pulse)
   );

endmodule

`default_nettype wire

// File: tb/tb_key_scan_pulse.sv
// ---------------------------------------------------------------------------
// tb_key_scan_pulse : directed stimulus with a pulse scoreboard and key checks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_key_scan_pulse;
   import key_pkg::*;

   localparam int SCAN_DIV = 4;
   localparam int DB       = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row_in;
   logic        btn_sel = 1'b0;
   logic        btn_next = 1'b0;
   logic [3:0]  col_out;
   logic [4:0]  key, key_pulse;
   logic [15:0] mat = '0;

   int cyc;
   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [4:0] code;
      int         at;
   } exp_t;
   exp_t sbq[$];

   key_scan_pulse #(
      .SCAN_DIV(SCAN_DIV),
      .DEBOUNCE_SCANS(DB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row_in    (row_in),
      .btn_sel   (btn_sel),
      .btn_next  (btn_next),
      .col_out   (col_out),
      .key       (key),
      .key_pulse (key_pulse)
   );

   always #5 clk = ~clk;

   // Matrix model: key c*4+r pulls row r low while column c is driven low.
   always_comb begin
      row_in = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (mat[c*4+r] && !col_out[c]) row_in[r] = 1'b0;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
   endtask

   task automatic goto(input int e);
      int guard = 0;
      while (cyc != e && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != e) check("goto_timeout", cyc, e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (key_pulse !== KEY_NONE) begin
            if (sbq.size() == 0) begin
               check("unexpected_pulse", key_pulse, KEY_NONE);
            end else begin
               e = sbq.pop_front();
               check("pulse_code", key_pulse, e.code);
               check("pulse_cycle", cyc, e.at);
            end
         end
      end
   end

   initial begin : stim
      // 1: reset and column walk
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_col", col_out, 4'b1110);
      check("rst_key", key, KEY_NONE);
      check("rst_pulse", key_pulse, KEY_NONE);
      rst = 1'b0;
      goto(3);  check("col0_hold", col_out, 4'b1110);
      goto(4);  check("col1", col_out, 4'b1101);
      goto(8);  check("col2", col_out, 4'b1011);
      goto(12); check("col3", col_out, 4'b0111);
      goto(16); check("col_wrap", col_out, 4'b1110);
      check("idle_key", key, KEY_NONE);

      // 2: btn_next held 10 frames, then released
      btn_next = 1'b1;
      sbq.push_back('{KEY_NEXT, 64});
      goto(63);  check("next_early", key, KEY_NONE);
      goto(64);  check("next_key", key, KEY_NEXT);
      goto(176); check("next_held", key, KEY_NEXT);
      btn_next = 1'b0;
      goto(223); check("next_rel_early", key, KEY_NEXT);
      goto(224); check("next_rel", key, KEY_NONE);

      // 3: matrix key 9, then roll-over to key 3
      mat[9] = 1'b1;
      sbq.push_back('{5'h09, 272});
      goto(271); check("k9_early", key, KEY_NONE);
      goto(272); check("k9_key", key, 5'h09);
      goto(288);
      mat[3] = 1'b1;
      sbq.push_back('{5'h03, 336});
      goto(335); check("k3_early", key, 5'h09);
      goto(336); check("k3_key", key, 5'h03);
      mat = '0;
      goto(384); check("k3_rel", key, KEY_NONE);

      // 4: bouncing btn_next never accepted
      btn_next = 1'b1;
      goto(400); btn_next = 1'b0;
      goto(416); btn_next = 1'b1;
      goto(432); btn_next = 1'b0;
      goto(480); check("bounce_key", key, KEY_NONE);

      // 5: btn_sel outranks matrix key 7
      btn_sel = 1'b1;
      mat[7]  = 1'b1;
      sbq.push_back('{KEY_SEL, 528});
      goto(527); check("sel_early", key, KEY_NONE);
      goto(528); check("sel_key", key, KEY_SEL);
      btn_sel = 1'b0;
      mat     = '0;
      goto(576); check("sel_rel", key, KEY_NONE);

      // 6: reset in the middle of a held btn_sel
      btn_sel = 1'b1;
      goto(600);
      rst = 1'b1;
      #1;
      check("midrst_col", col_out, 4'b1110);
      check("midrst_key", key, KEY_NONE);
      check("midrst_pulse", key_pulse, KEY_NONE);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      sbq.push_back('{KEY_SEL, 48});
      goto(47); check("postrst_early", key, KEY_NONE);
      goto(48); check("postrst_key", key, KEY_SEL);
      btn_sel = 1'b0;
      goto(96); check("postrst_rel", key, KEY_NONE);

      goto(110);
      check("scoreboard_empty", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
